// File: rtl/queue_ctrl.sv
// ============================================================================
// Module      : queue_ctrl
// Description : Control core for a single-clock queue. Qualifies push/pop
//               requests against occupancy, drives storage pointers, keeps the
//               occupancy count, status flags and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_ctrl #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic          err_clr_i,
  output logic          wr_en_o,
  output logic          rd_en_o,
  output logic [1:0]    op_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [AW-1:0] C_PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_AF       = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   C_AE       = (AW+1)'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, almost_full_q, almost_empty_q;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          w_wr, w_rd;

  // Acceptance: a pop on a full queue frees the slot for a same-cycle push;
  // a flush suppresses both so no storage access happens.
  always_comb begin
    w_rd = pop_i & ~empty_q & ~clr_i;
    w_wr = push_i & (~full_q | pop_i) & ~clr_i;
  end

  // Next-state for pointers, occupancy and sticky errors (set wins over clear).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr) wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + C_PTR_ONE;
      if (w_rd) rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + C_PTR_ONE;
      case ({w_wr, w_rd})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    overflow_d  = (overflow_q  & ~err_clr_i) | (push_i & ~w_wr & ~clr_i);
    underflow_d = (underflow_q & ~err_clr_i) | (pop_i  & ~w_rd & ~clr_i);
  end

  // State registers; flags are derived from the next count so they line up with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= (count_d == C_DEPTH);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= C_AF);
      almost_empty_q <= (count_d <= C_AE);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Enables are held low while reset is asserted.
  always_comb begin
    wr_en_o = w_wr & rst_n;
    rd_en_o = w_rd & rst_n;
    op_o    = {w_rd & rst_n, w_wr & rst_n};
  end

  assign wr_ptr_o       = wr_ptr_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_queue_ctrl.sv
// ============================================================================
// Module      : tb_queue_ctrl
// Description : Directed self-checking bench for queue_ctrl (DEPTH=16 and 5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_queue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // DEPTH=16 instance
  logic       push = 0, pop = 0, clr = 0, err_clr = 0;
  logic       wr_en, rd_en, full, empty, af, ae, ovf, udf;
  logic [1:0] op;
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;

  // DEPTH=5 instance
  logic       p5 = 0, q5 = 0;
  logic       wr_en5, rd_en5, full5, empty5, af5, ae5, ovf5, udf5;
  logic [1:0] op5;
  logic [2:0] wr_ptr5, rd_ptr5;
  logic [3:0] count5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  queue_ctrl #(.DEPTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .clr_i(clr),
    .err_clr_i(err_clr), .wr_en_o(wr_en), .rd_en_o(rd_en), .op_o(op),
    .wr_ptr_o(wr_ptr), .rd_ptr_o(rd_ptr), .count_o(count), .full_o(full),
    .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
    .overflow_o(ovf), .underflow_o(udf)
  );

  queue_ctrl #(.DEPTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .push_i(p5), .pop_i(q5), .clr_i(1'b0),
    .err_clr_i(1'b0), .wr_en_o(wr_en5), .rd_en_o(rd_en5), .op_o(op5),
    .wr_ptr_o(wr_ptr5), .rd_ptr_o(rd_ptr5), .count_o(count5), .full_o(full5),
    .empty_o(empty5), .almost_full_o(af5), .almost_empty_o(ae5),
    .overflow_o(ovf5), .underflow_o(udf5)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic c, input logic e);
    push = p; pop = q; clr = c; err_clr = e;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mwr, mrd, mcnt;
    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0);
    tick;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", ae, 1);
    chk("rst_full", full, 0);
    chk("rst_af", af, 0);
    chk("rst_op", op, 0);
    chk("rst_wptr", wr_ptr, 0);
    chk("rst_rptr", rd_ptr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);

    // Fill to 16
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0);
      chk("fill_wr_en", wr_en, 1);
      tick;
      chk("fill_count", count, i + 1);
      chk("fill_af", af, (i + 1 >= 14) ? 1 : 0);
      chk("fill_ae", ae, (i + 1 <= 2) ? 1 : 0);
      chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
    end
    chk("fill_wptr_wrap", wr_ptr, 0);

    // 17th push rejected
    drive(1, 0, 0, 0);
    chk("ovf_wr_en", wr_en, 0);
    chk("ovf_op", op, 0);
    tick;
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 16);
    drive(0, 0, 0, 0);
    tick;
    chk("ovf_sticky", ovf, 1);

    // Full, push&pop together
    drive(1, 1, 0, 0);
    chk("fullpp_op", op, 3);
    tick;
    chk("fullpp_count", count, 16);
    chk("fullpp_wptr", wr_ptr, 1);
    chk("fullpp_rptr", rd_ptr, 1);
    chk("fullpp_ovf", ovf, 1);

    // err_clr clears; then set wins over clear
    drive(0, 0, 0, 1);
    tick;
    chk("errclr_ovf", ovf, 0);
    drive(1, 0, 0, 1);
    tick;
    chk("setwins_ovf", ovf, 1);
    drive(0, 0, 0, 1);
    tick;
    chk("errclr2_ovf", ovf, 0);

    // Drain to empty
    for (int i = 16; i > 0; i--) begin
      drive(0, 1, 0, 0);
      chk("drain_rd_en", rd_en, 1);
      tick;
      chk("drain_count", count, i - 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_rptr", rd_ptr, 1);
    chk("drain_udf", udf, 0);

    // Empty, push&pop: only push accepted
    drive(1, 1, 0, 0);
    chk("emptypp_op", op, 1);
    tick;
    chk("emptypp_count", count, 1);
    chk("emptypp_udf", udf, 1);
    drive(0, 1, 0, 0);
    chk("popalone_op", op, 2);
    tick;
    chk("popalone_count", count, 0);
    chk("popalone_empty", empty, 1);

    // Fill to 7 then flush with push held
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0);
      tick;
    end
    chk("pre_clr_count", count, 7);
    drive(1, 0, 1, 0);
    chk("clr_wr_en", wr_en, 0);
    chk("clr_op", op, 0);
    tick;
    chk("clr_count", count, 0);
    chk("clr_wptr", wr_ptr, 0);
    chk("clr_rptr", rd_ptr, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", ovf, 0);
    chk("clr_udf_kept", udf, 1);

    // Resume pushing then async reset mid-burst, no clock edge before checks
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      tick;
    end
    chk("burst_count", count, 3);
    rst_n = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_wr_en", wr_en, 0);
    chk("async_op", op, 0);
    chk("async_empty", empty, 1);
    chk("async_ae", ae, 1);
    chk("async_wptr", wr_ptr, 0);
    chk("async_udf", udf, 0);
    drive(0, 0, 0, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // DEPTH=5 wrap: prefill 2, then 12 push/pop pairs against a model
    mwr = 0; mrd = 0; mcnt = 0;
    for (int i = 0; i < 2; i++) begin
      p5 = 1; q5 = 0;
      tick;
      mwr = (mwr + 1) % 5; mcnt++;
    end
    for (int k = 0; k < 24; k++) begin
      p5 = (k % 2 == 0); q5 = (k % 2 == 1);
      tick;
      if (k % 2 == 0) begin mwr = (mwr + 1) % 5; mcnt++; end
      else begin mrd = (mrd + 1) % 5; mcnt--; end
      chk("d5_wptr", wr_ptr5, mwr);
      chk("d5_rptr", rd_ptr5, mrd);
      chk("d5_count", count5, mcnt);
      chk("d5_range", (wr_ptr5 < 5 && rd_ptr5 < 5) ? 1 : 0, 1);
    end
    p5 = 0; q5 = 0;
    chk("d5_ovf", ovf5, 0);
    chk("d5_udf", udf5, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
